// File: rtl/seq_pkg.sv
// Shared types and opcode constants for the program sequencer.
// Holds the FSM state type and the instruction-class decoder.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_DONE   = 3'd6
    } state_e;

    localparam logic [2:0] OP_RTYPE0 = 3'b000;
    localparam logic [2:0] OP_RTYPE1 = 3'b001;
    localparam logic [2:0] OP_RTYPE2 = 3'b010;
    localparam logic [2:0] OP_IMM    = 3'b011;
    localparam logic [2:0] OP_LOAD   = 3'b100;
    localparam logic [2:0] OP_STORE  = 3'b101;
    localparam logic [2:0] OP_BRANCH = 3'b110;
    localparam logic [2:0] OP_HALT   = 3'b111;

    typedef struct packed {
        logic reg_dst;
        logic mem_to_reg;
        logic mem_write;
        logic branch;
    } cls_t;

    function automatic cls_t decode_cls(input logic [2:0] op);
        cls_t c;
        c = '0;
        case (op)
            OP_RTYPE0,
            OP_RTYPE1,
            OP_RTYPE2: c.reg_dst = 1'b1;
            OP_LOAD: begin
                c.reg_dst    = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            OP_STORE: begin
                c.reg_dst   = 1'b1;
                c.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                c.reg_dst = 1'b1;
                c.branch  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/seq_perf_cnt.sv
// Saturating cycle and instruction counters for the sequencer.
// Cleared at run start; they stop naturally when the run ends.
module seq_perf_cnt (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        clr_i,
    input  logic        cyc_inc_i,
    input  logic        ins_inc_i,
    output logic [15:0] cycle_cnt_o,
    output logic [15:0] instr_cnt_o
);

    logic [15:0] cyc_q;
    logic [15:0] ins_q;

    // count busy cycles and decodes, saturating at all-ones
    always_ff @(posedge Clk) begin
        if (Reset || clr_i) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            if (cyc_inc_i && (cyc_q != 16'hFFFF))
                cyc_q <= cyc_q + 16'd1;
            if (ins_inc_i && (ins_q != 16'hFFFF))
                ins_q <= ins_q + 16'd1;
        end
    end

    assign cycle_cnt_o = cyc_q;
    assign instr_cnt_o = ins_q;

endmodule

// File: rtl/prog_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer with Start/Ack.
// Define SEQ_PERF_CNT_EN to add cycle_cnt/instr_cnt outputs.
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [8:0]      mach_code,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] target,
    input  logic            mem_ready,
    output logic [PC_W-1:0] pc,
    output logic [8:0]      ir,
    output logic            RegDst,
    output logic            MemtoReg,
    output logic            MemWrite,
    output logic            Branch,
    output logic            reg_we,
    output logic            mem_req,
    output logic            mem_we,
    output logic            busy,
    output logic            Ack,
    output logic            mem_err
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]     cycle_cnt,
    output logic [15:0]     instr_cnt
`endif
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc;
    logic [8:0]      ir_q, ir_d;
    cls_t            cls_q, cls_d;
    logic            err_q, err_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            busy_q, busy_d;
    logic            ack_q, ack_d;
    logic [2:0]      op;

    assign pc_inc = pc_q + PC_W'(1);
    assign op     = ir_q[8:6];

    // next-state, pc, ir, class and timeout update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cls_d   = cls_q;
        err_d   = err_q;
        tmo_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    pc_d    = '0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = mach_code;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (op == OP_HALT) begin
                    cls_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cls_d   = decode_cls(op);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls_q.branch) begin
                    pc_d    = branch_taken ? target : pc_inc;
                    state_d = S_FETCH;
                end else if (cls_q.mem_to_reg || cls_q.mem_write) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (cls_q.mem_write) begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    cls_d   = '0;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WB: begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end
            S_DONE: begin
                if (!Start)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        ack_d  = (state_d == S_DONE);
    end

    // state and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            cls_q   <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cls_q   <= cls_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign pc       = pc_q;
    assign ir       = ir_q;
    assign RegDst   = cls_q.reg_dst;
    assign MemtoReg = cls_q.mem_to_reg;
    assign MemWrite = cls_q.mem_write;
    assign Branch   = cls_q.branch;
    assign busy     = busy_q;
    assign Ack      = ack_q;
    assign mem_err  = err_q;
    assign mem_req  = (state_q == S_MEM);
    assign mem_we   = (state_q == S_MEM) && cls_q.mem_write;
    assign reg_we   = (state_q == S_WB);

`ifdef SEQ_PERF_CNT_EN
    logic perf_clr;
    logic perf_ins;

    assign perf_clr = (state_q == S_IDLE) && Start;
    assign perf_ins = (state_q == S_DECODE);

    seq_perf_cnt u_perf (
        .Clk         (Clk),
        .Reset       (Reset),
        .clr_i       (perf_clr),
        .cyc_inc_i   (busy_q),
        .ins_inc_i   (perf_ins),
        .cycle_cnt_o (cycle_cnt),
        .instr_cnt_o (instr_cnt)
    );
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed and random program runs against an instruction-level model.
// The model emits a per-cycle trace of expected outputs and drives.
module tb_prog_sequencer;

    logic       Clk = 1'b0;
    logic       Reset, Start, branch_taken, mem_ready;
    logic [7:0] target, pc;
    logic [8:0] mach_code, ir;
    logic       RegDst, MemtoReg, MemWrite, Branch;
    logic       reg_we, mem_req, mem_we, busy, Ack, mem_err;

    logic [8:0] rom [256];
    assign mach_code = rom[pc];

    always #5 Clk = ~Clk;

    prog_sequencer #(.PC_W(8), .MEM_TIMEOUT(15)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .mach_code(mach_code), .branch_taken(branch_taken),
        .target(target), .mem_ready(mem_ready),
        .pc(pc), .ir(ir),
        .RegDst(RegDst), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .Branch(Branch),
        .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we),
        .busy(busy), .Ack(Ack), .mem_err(mem_err)
    );

    typedef struct packed {
        logic [7:0] pc;
        logic [8:0] ir;
        logic [3:0] cls;
        logic       reg_we, mem_req, mem_we, busy, ack, err;
    } exp_t;

    typedef struct packed {
        logic       start, rdy, bt;
        logic [7:0] tg;
    } drv_t;

    exp_t       eq[$];
    drv_t       dv[$];
    int         dly_q[$];
    bit         bt_q[$];
    logic [7:0] tg_q[$];

    logic [7:0] m_pc;
    logic [8:0] m_ir;
    logic [3:0] m_cls;
    logic       m_err;
    bit         start_hi;
    int         n_pass, n_tot, n_fail;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic bstart();
        return start_hi ? 1'b1 : rbit();
    endfunction

    // {RegDst, MemtoReg, MemWrite, Branch} for an opcode
    function automatic logic [3:0] classify(input logic [2:0] op);
        logic rd, m2r, mw, br;
        rd  = !(op == 3'd3 || op == 3'd7);
        m2r = (op == 3'd4);
        mw  = (op == 3'd5);
        br  = (op == 3'd6);
        return {rd, m2r, mw, br};
    endfunction

    task automatic push(input logic bz, input logic wb,
                        input logic mrq, input logic mwe,
                        input logic ak, input logic st,
                        input logic rdy, input logic bt,
                        input logic [7:0] tg);
        exp_t e;
        drv_t d;
        e.pc = m_pc; e.ir = m_ir; e.cls = m_cls;
        e.reg_we = wb; e.mem_req = mrq; e.mem_we = mwe;
        e.busy = bz; e.ack = ak; e.err = m_err;
        d.start = st; d.rdy = rdy; d.bt = bt; d.tg = tg;
        eq.push_back(e);
        dv.push_back(d);
    endtask

    task automatic plain();
        push(1, 0, 0, 0, 0, bstart(), rbit(), rbit(), 8'($urandom));
    endtask

    task automatic finish_done();
        int h;
        m_cls = '0;
        h = $urandom_range(0, 3);
        repeat (h) push(0, 0, 0, 0, 1, 1, rbit(), rbit(), 8'($urandom));
        push(0, 0, 0, 0, 1, 0, rbit(), rbit(), 8'($urandom));
        push(0, 0, 0, 0, 0, 0, rbit(), rbit(), 8'($urandom));
    endtask

    task automatic build(input int budget, input int abort_k,
                         output bit trunc);
        int n;
        bit fin;
        eq.delete();
        dv.delete();
        trunc = 0;
        fin = 0;
        n = 0;
        push(0, 0, 0, 0, 0, 1, rbit(), rbit(), 8'($urandom));
        m_pc = 8'h00;
        m_err = 1'b0;
        while (!fin) begin
            logic [8:0] ins;
            logic [2:0] op;
            if (n == budget) begin
                trunc = 1;
                break;
            end
            n++;
            ins = rom[m_pc];
            op = ins[8:6];
            plain();
            m_ir = ins;
            plain();
            if (op == 3'd7) begin
                finish_done();
                fin = 1;
                continue;
            end
            m_cls = classify(op);
            if (op == 3'd6) begin
                logic bt;
                logic [7:0] tg;
                if (bt_q.size() > 0) begin
                    bt = bt_q.pop_front();
                    tg = tg_q.pop_front();
                end else begin
                    bt = rbit();
                    tg = 8'($urandom);
                end
                push(1, 0, 0, 0, 0, bstart(), rbit(), bt, tg);
                m_pc = bt ? tg : m_pc + 8'd1;
                continue;
            end
            plain();
            if (op == 3'd4 || op == 3'd5) begin
                int d;
                bit got;
                if (dly_q.size() > 0) begin
                    d = dly_q.pop_front();
                end else begin
                    d = $urandom_range(0, 9);
                    d = (d == 0) ? 0 : (d == 1) ? 15 : d - 1;
                end
                got = 0;
                for (int i = 1; i <= 15; i++) begin
                    push(1, 0, 1, (op == 3'd5), 0, bstart(),
                         (i == d), rbit(), 8'($urandom));
                    if (i == d) begin
                        got = 1;
                        break;
                    end
                end
                if (!got) begin
                    m_err = 1'b1;
                    finish_done();
                    fin = 1;
                    continue;
                end
                if (op == 3'd5) begin
                    m_pc = m_pc + 8'd1;
                    continue;
                end
            end
            push(1, 1, 0, 0, 0, bstart(), rbit(), rbit(), 8'($urandom));
            m_pc = m_pc + 8'd1;
        end
        if (abort_k > 0 && abort_k < eq.size() - 1) begin
            trunc = 1;
            while (eq.size() > abort_k + 1) begin
                void'(eq.pop_back());
                void'(dv.pop_back());
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] ex);
        n_tot++;
        assert (obs === ex) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, ex);
        end
    endtask

    task automatic check_cycle(input string nm, input int k,
                               input exp_t e);
        string t;
        t = $sformatf("%s[%0d]", nm, k);
        chk({t, ".pc"}, 32'(pc), 32'(e.pc));
        chk({t, ".ir"}, 32'(ir), 32'(e.ir));
        chk({t, ".cls"}, 32'({RegDst, MemtoReg, MemWrite, Branch}),
            32'(e.cls));
        chk({t, ".reg_we"}, 32'(reg_we), 32'(e.reg_we));
        chk({t, ".mem_req"}, 32'(mem_req), 32'(e.mem_req));
        chk({t, ".mem_we"}, 32'(mem_we), 32'(e.mem_we));
        chk({t, ".busy"}, 32'(busy), 32'(e.busy));
        chk({t, ".Ack"}, 32'(Ack), 32'(e.ack));
        chk({t, ".mem_err"}, 32'(mem_err), 32'(e.err));
    endtask

    task automatic run_prog(input string nm, input int budget,
                            input int abort_k);
        bit trunc;
        exp_t z;
        build(budget, abort_k, trunc);
        for (int k = 0; k < eq.size(); k++) begin
            @(posedge Clk);
            #1;
            check_cycle(nm, k, eq[k]);
            Start        = dv[k].start;
            mem_ready    = dv[k].rdy;
            branch_taken = dv[k].bt;
            target       = dv[k].tg;
        end
        if (trunc) begin
            Reset = 1'b1;
            @(posedge Clk);
            #1;
            Reset = 1'b0;
            Start = 1'b0;
            m_pc = '0; m_ir = '0; m_cls = '0; m_err = 1'b0;
            z = '0;
            check_cycle({nm, "_rst"}, 0, z);
        end
    endtask

    task automatic rom_halt();
        for (int a = 0; a < 256; a++) rom[a] = 9'h1C0;
    endtask

    task automatic rom_rand();
        for (int a = 0; a < 256; a++) begin
            int r;
            logic [2:0] op;
            r = $urandom_range(0, 15);
            op = (r < 6)  ? 3'(r % 3) :
                 (r < 8)  ? 3'd3 :
                 (r < 10) ? 3'd4 :
                 (r < 12) ? 3'd5 :
                 (r < 14) ? 3'd6 : 3'd7;
            rom[a] = {op, 6'($urandom)};
        end
    endtask

    initial begin
        exp_t z;
        n_pass = 0; n_tot = 0; n_fail = 0;
        m_pc = '0; m_ir = '0; m_cls = '0; m_err = 1'b0;
        start_hi = 1;
        Reset = 1'b1; Start = 1'b0; mem_ready = 1'b0;
        branch_taken = 1'b0; target = 8'h00;
        rom_halt();
        repeat (2) @(posedge Clk);
        #1;
        z = '0;
        check_cycle("reset", 0, z);
        Reset = 1'b0;

        rom[0] = 9'h000;
        run_prog("rhalt", 50, 0);

        start_hi = 0;
        rom_halt();
        rom[0] = 9'h100;
        dly_q.push_back(3);
        run_prog("load3", 50, 0);

        rom[0] = 9'h180;
        bt_q.push_back(1); tg_q.push_back(8'h40);
        run_prog("br_t", 50, 0);

        bt_q.push_back(0); tg_q.push_back(8'h40);
        run_prog("br_nt", 50, 0);

        rom[0] = 9'h140;
        dly_q.push_back(0);
        run_prog("st_tmo", 50, 0);

        dly_q.push_back(15);
        run_prog("st_15", 50, 0);

        rom[0] = 9'h180;
        rom[255] = 9'h000;
        bt_q.push_back(1); tg_q.push_back(8'hFF);
        bt_q.push_back(0); tg_q.push_back(8'h10);
        run_prog("wrap", 50, 0);

        start_hi = 1;
        rom_halt();
        rom[0] = 9'h100;
        dly_q.push_back(0);
        run_prog("rst_mem", 50, 6);

        for (int r = 0; r < 30; r++) begin
            int ab;
            rom_rand();
            start_hi = bit'($urandom_range(0, 1));
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(3, 40) : 0;
            run_prog($sformatf("rnd%0d", r), 40, ab);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
